fila_parametrizada: RTL and testbench

- Parametrised synchronous circular-buffer FIFO (fila); next generation of the 8-bit queue used on the 10 kHz system clock.
- Adds generic data width and depth, full/empty flags, overflow/underflow pulses, and defined simultaneous enqueue/dequeue.
- Sits between producer logic (keys/serial input) and consumer logic (display/output path).

---
 rtl/fila_pkg.sv | 23 ++
 rtl/fila_mem.sv | 36 +++
 rtl/fila_parametrizada.sv | 114 +++++++++++
 tb/tb_fila_parametrizada.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fila_pkg.sv
// Shared defaults, pointer wrap helper and operation decode type for the fila FIFO.
package fila_pkg;

  localparam int unsigned FILA_DATA_W_DEF = 8;
  localparam int unsigned FILA_DEPTH_DEF  = 8;

  // Accepted-operation case for one clock edge.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_ENQ  = 2'b01,
    OP_DEQ  = 2'b10,
    OP_BOTH = 2'b11
  } fila_op_e;

  // Circular increment; depth need not be a power of two.
  function automatic logic [31:0] ptr_next(input logic [31:0] ptr, input logic [31:0] depth);
    if (ptr == depth - 32'd1) begin
      return 32'd0;
    end
    return ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fila_mem.sv
// DEPTH x DATA_W register array: synchronous write port, registered read port.
// The read register is the FIFO's data_out, so it alone is cleared by reset.
module fila_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; reads the pre-write value when addresses coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/fila_parametrizada.sv
// Parametrised circular-buffer FIFO with full/empty flags and overflow/underflow pulses.
// Optional almost-full/almost-empty outputs are enabled by defining FILA_ALMOST_FLAGS_EN.
module fila_parametrizada
  import fila_pkg::*;
#(
  parameter int unsigned DATA_W = FILA_DATA_W_DEF,
  parameter int unsigned DEPTH  = FILA_DEPTH_DEF,
`ifdef FILA_ALMOST_FLAGS_EN
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1,
`endif
  localparam int unsigned LEN_W = $clog2(DEPTH + 1)
) (
  input  logic              clk_10KHz,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              enqueue_in,
  input  logic              dequeue_in,
`ifdef FILA_ALMOST_FLAGS_EN
  output logic              almost_full_out,
  output logic              almost_empty_out,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic [LEN_W-1:0]  len_out,
  output logic              full_out,
  output logic              empty_out,
  output logic              overflow_out,
  output logic              underflow_out
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             full, empty;
  logic             enq_acc, deq_acc;
  fila_op_e         op;

  assign full  = (len_q == LEN_W'(DEPTH));
  assign empty = (len_q == '0);

  // Dequeue frees a slot in the same edge, so a full queue still accepts a paired enqueue.
  assign deq_acc = dequeue_in & ~empty;
  assign enq_acc = enqueue_in & (~full | deq_acc);
  assign op      = fila_op_e'({deq_acc, enq_acc});

  // Pointer, count and pulse state.
  always_ff @(posedge clk_10KHz) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      len_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      len_q  <= len_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  // Next-state from the decoded accepted operation.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    len_d  = len_q;
    ovf_d  = enqueue_in & ~enq_acc;
    unf_d  = dequeue_in & ~deq_acc;
    if (enq_acc) begin
      tail_d = AW'(ptr_next(32'(tail_q), DEPTH));
    end
    if (deq_acc) begin
      head_d = AW'(ptr_next(32'(head_q), DEPTH));
    end
    unique case (op)
      OP_ENQ:  len_d = len_q + LEN_W'(1);
      OP_DEQ:  len_d = len_q - LEN_W'(1);
      OP_BOTH: len_d = len_q;
      default: len_d = len_q;
    endcase
  end

  fila_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk_10KHz),
    .reset   (reset),
    .wr_en   (enq_acc),
    .wr_addr (tail_q),
    .wr_data (data_in),
    .rd_en   (deq_acc),
    .rd_addr (head_q),
    .rd_data (data_out)
  );

  assign len_out       = len_q;
  assign full_out      = full;
  assign empty_out     = empty;
  assign overflow_out  = ovf_q;
  assign underflow_out = unf_q;

`ifdef FILA_ALMOST_FLAGS_EN
  assign almost_full_out  = (32'(len_q) >= AF_LEVEL);
  assign almost_empty_out = (32'(len_q) <= AE_LEVEL);
`endif

endmodule

// File: tb/tb_fila_parametrizada.sv
// Directed bench: DEPTH=8/DATA_W=8 instance plus a DEPTH=5/DATA_W=12 instance.
module tb_fila_parametrizada;

  logic        clk = 1'b0;
  logic        reset;

  logic [7:0]  a_din;
  logic        a_enq, a_deq;
  logic [7:0]  a_dout;
  logic [3:0]  a_len;
  logic        a_full, a_empty, a_ovf, a_unf;

  logic [11:0] b_din;
  logic        b_enq, b_deq;
  logic [11:0] b_dout;
  logic [2:0]  b_len;
  logic        b_full, b_empty, b_ovf, b_unf;
`ifdef FILA_ALMOST_FLAGS_EN
  logic        a_af, a_ae, b_af, b_ae;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fila_parametrizada #(
    .DATA_W (8),
    .DEPTH  (8)
  ) u_dut_a (
    .clk_10KHz        (clk),
    .reset            (reset),
    .data_in          (a_din),
    .enqueue_in       (a_enq),
    .dequeue_in       (a_deq),
`ifdef FILA_ALMOST_FLAGS_EN
    .almost_full_out  (a_af),
    .almost_empty_out (a_ae),
`endif
    .data_out         (a_dout),
    .len_out          (a_len),
    .full_out         (a_full),
    .empty_out        (a_empty),
    .overflow_out     (a_ovf),
    .underflow_out    (a_unf)
  );

  fila_parametrizada #(
    .DATA_W (12),
    .DEPTH  (5)
  ) u_dut_b (
    .clk_10KHz        (clk),
    .reset            (reset),
    .data_in          (b_din),
    .enqueue_in       (b_enq),
    .dequeue_in       (b_deq),
`ifdef FILA_ALMOST_FLAGS_EN
    .almost_full_out  (b_af),
    .almost_empty_out (b_ae),
`endif
    .data_out         (b_dout),
    .len_out          (b_len),
    .full_out         (b_full),
    .empty_out        (b_empty),
    .overflow_out     (b_ovf),
    .underflow_out    (b_unf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_push(input logic [7:0] v);
    a_din = v; a_enq = 1'b1; a_deq = 1'b0;
    tick();
    a_enq = 1'b0;
  endtask

  task automatic a_pop(input string tag, input logic [7:0] exp);
    a_enq = 1'b0; a_deq = 1'b1;
    tick();
    a_deq = 1'b0;
    check_eq(tag, 32'(a_dout), 32'(exp));
  endtask

  task automatic b_push(input logic [11:0] v);
    b_din = v; b_enq = 1'b1; b_deq = 1'b0;
    tick();
    b_enq = 1'b0;
  endtask

  task automatic b_pop(input string tag, input logic [11:0] exp);
    b_enq = 1'b0; b_deq = 1'b1;
    tick();
    b_deq = 1'b0;
    check_eq(tag, 32'(b_dout), 32'(exp));
  endtask

  initial begin
    reset = 1'b1;
    a_din = '0; a_enq = 1'b0; a_deq = 1'b0;
    b_din = '0; b_enq = 1'b0; b_deq = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check_eq("rst_len", 32'(a_len), 32'd0);
    check_eq("rst_empty", 32'(a_empty), 32'd1);
    check_eq("rst_full", 32'(a_full), 32'd0);
    check_eq("rst_dout", 32'(a_dout), 32'd0);
    check_eq("rst_ovf", 32'(a_ovf), 32'd0);
    check_eq("rst_unf", 32'(a_unf), 32'd0);
`ifdef FILA_ALMOST_FLAGS_EN
    check_eq("rst_af", 32'(a_af), 32'd0);
    check_eq("rst_ae", 32'(a_ae), 32'd1);
`endif

    // Fill 0x11..0x88
    for (int i = 1; i <= 8; i++) begin
      a_push(8'(i * 8'h11));
      check_eq("fill_len", 32'(a_len), 32'(i));
    end
    check_eq("fill_full", 32'(a_full), 32'd1);
    check_eq("fill_empty", 32'(a_empty), 32'd0);
    check_eq("fill_ovf_quiet", 32'(a_ovf), 32'd0);

    // Overflow
    a_push(8'h99);
    check_eq("ovf_pulse", 32'(a_ovf), 32'd1);
    check_eq("ovf_len", 32'(a_len), 32'd8);
    tick();
    check_eq("ovf_clear", 32'(a_ovf), 32'd0);

    // Drain in order
    for (int i = 1; i <= 8; i++) begin
      a_pop("drain_data", 8'(i * 8'h11));
      check_eq("drain_len", 32'(a_len), 32'(8 - i));
    end
    check_eq("drain_empty", 32'(a_empty), 32'd1);

    // Underflow
    a_pop("unf_hold", 8'h88);
    check_eq("unf_pulse", 32'(a_unf), 32'd1);
    check_eq("unf_len", 32'(a_len), 32'd0);
    tick();
    check_eq("unf_clear", 32'(a_unf), 32'd0);

    // Wrap-around
    for (int i = 0; i < 6; i++) a_push(8'(8'hB0 + i));
    for (int i = 0; i < 4; i++) a_pop("wrap_first", 8'(8'hB0 + i));
    for (int i = 0; i < 5; i++) a_push(8'(8'hA0 + i));
    check_eq("wrap_len", 32'(a_len), 32'd7);
    a_pop("wrap_orig4", 8'hB4);
    a_pop("wrap_orig5", 8'hB5);
    for (int i = 0; i < 5; i++) a_pop("wrap_new", 8'(8'hA0 + i));
    check_eq("wrap_empty", 32'(a_empty), 32'd1);

    // Simultaneous when full
    for (int i = 0; i < 8; i++) a_push(8'(8'hC0 + i));
    a_din = 8'hEE; a_enq = 1'b1; a_deq = 1'b1;
    tick();
    a_enq = 1'b0; a_deq = 1'b0;
    check_eq("both_full_dout", 32'(a_dout), 32'hC0);
    check_eq("both_full_len", 32'(a_len), 32'd8);
    check_eq("both_full_ovf", 32'(a_ovf), 32'd0);
    check_eq("both_full_unf", 32'(a_unf), 32'd0);
    for (int i = 1; i < 8; i++) a_pop("both_full_rest", 8'(8'hC0 + i));
    a_pop("both_full_last", 8'hEE);
    check_eq("both_full_empty", 32'(a_empty), 32'd1);

    // Simultaneous when empty
    a_din = 8'h5A; a_enq = 1'b1; a_deq = 1'b1;
    tick();
    a_enq = 1'b0; a_deq = 1'b0;
    check_eq("both_empty_unf", 32'(a_unf), 32'd1);
    check_eq("both_empty_len", 32'(a_len), 32'd1);
    check_eq("both_empty_nobypass", 32'(a_dout), 32'hEE);
    a_pop("both_empty_next", 8'h5A);
    check_eq("both_empty_unf_clr", 32'(a_unf), 32'd0);

    // Mid-range both: len unchanged
    a_push(8'h01);
    a_push(8'h02);
    a_din = 8'h03; a_enq = 1'b1; a_deq = 1'b1;
    tick();
    a_enq = 1'b0; a_deq = 1'b0;
    check_eq("mid_both_dout", 32'(a_dout), 32'h01);
    check_eq("mid_both_len", 32'(a_len), 32'd2);

    // Reset mid-operation with len 5 and both requests high
    for (int i = 0; i < 3; i++) a_push(8'(8'h70 + i));
    check_eq("pre_rst_len", 32'(a_len), 32'd5);
    reset = 1'b1; a_din = 8'hFF; a_enq = 1'b1; a_deq = 1'b1;
    tick();
    reset = 1'b0; a_enq = 1'b0; a_deq = 1'b0;
    check_eq("mrst_len", 32'(a_len), 32'd0);
    check_eq("mrst_dout", 32'(a_dout), 32'd0);
    check_eq("mrst_empty", 32'(a_empty), 32'd1);
    check_eq("mrst_ovf", 32'(a_ovf), 32'd0);
    check_eq("mrst_unf", 32'(a_unf), 32'd0);
    a_push(8'h33);
    a_pop("mrst_reuse", 8'h33);

    // DEPTH=5, DATA_W=12 instance
    for (int i = 1; i <= 5; i++) begin
      b_push(12'(i));
      check_eq("b_fill_len", 32'(b_len), 32'(i));
`ifdef FILA_ALMOST_FLAGS_EN
      check_eq("b_af", 32'(b_af), (i >= 4) ? 32'd1 : 32'd0);
      check_eq("b_ae", 32'(b_ae), (i <= 1) ? 32'd1 : 32'd0);
`endif
    end
    check_eq("b_full", 32'(b_full), 32'd1);
    b_push(12'h006);
    check_eq("b_ovf", 32'(b_ovf), 32'd1);
    check_eq("b_ovf_len", 32'(b_len), 32'd5);
    b_pop("b_pop1", 12'h001);
    check_eq("b_ovf_clear", 32'(b_ovf), 32'd0);
    b_pop("b_pop2", 12'h002);
    b_push(12'hABC);
    b_push(12'h7E1);
    check_eq("b_wrap_len", 32'(b_len), 32'd5);
    b_pop("b_pop3", 12'h003);
    b_pop("b_pop4", 12'h004);
    b_pop("b_pop5", 12'h005);
`ifdef FILA_ALMOST_FLAGS_EN
    check_eq("b_ae_len2", 32'(b_ae), 32'd0);
`endif
    b_pop("b_pop6", 12'hABC);
`ifdef FILA_ALMOST_FLAGS_EN
    check_eq("b_ae_len1", 32'(b_ae), 32'd1);
`endif
    b_pop("b_pop7", 12'h7E1);
    check_eq("b_empty", 32'(b_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
